// File: rtl/ef_adc_sar_ctrl.sv
// SAR controller for the 10-bit 8-channel ADC macro (sample, hold, MSB-first search); SAR_CTRL_SCAN_EN adds channel auto-scan.
// Latency: eoc N + RES*BIT_CYC edges after the accepting soc edge, N = max(sample_cycles,1).
// Backpressure: none; soc is ignored while busy and en=0 aborts an active conversion.
module ef_adc_sar_ctrl #(
    parameter int RES     = 10,
    parameter int BIT_CYC = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           soc,
    input  logic [2:0]     chan,
    input  logic [7:0]     sample_cycles,
    input  logic           cmp,
`ifdef SAR_CTRL_SCAN_EN
    input  logic           scan,
`endif
    output logic           adc_en,
    output logic           adc_rst,
    output logic           adc_hold,
    output logic [2:0]     adc_b,
    output logic [RES-1:0] adc_data,
    output logic [RES-1:0] result,
    output logic [2:0]     result_ch,
    output logic           eoc,
    output logic           busy
);
    localparam int BW = (RES > 1) ? $clog2(RES) : 1;
    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [BW-1:0] MSB_IDX  = BW'(RES - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONV} state_t;

    state_t         state_q, state_d;
    logic [7:0]     n_q, n_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic           hold_q, hold_d;
    logic           arst_q, arst_d;
    logic           busy_q, busy_d;
    logic           eoc_q, eoc_d;
    logic [2:0]     b_q, b_d;
    logic [2:0]     ch_q, ch_d;
    logic [RES-1:0] data_q, data_d;
    logic [RES-1:0] res_q, res_d;
    logic           scan_go;

`ifdef SAR_CTRL_SCAN_EN
    assign scan_go = scan;
`else
    assign scan_go = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        cyc_d   = cyc_q;
        hold_d  = hold_q;
        arst_d  = arst_q;
        busy_d  = busy_q;
        eoc_d   = 1'b0;
        b_d     = b_q;
        ch_d    = ch_q;
        data_d  = data_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (en && soc) begin
                    state_d = S_SAMPLE;
                    busy_d  = 1'b1;
                    arst_d  = 1'b0;
                    b_d     = chan;
                    hold_d  = 1'b0;
                    data_d  = '0;
                    n_d     = (sample_cycles == 8'd0) ? 8'd1 : sample_cycles;
                    cnt_d   = n_d - 8'd1;
                end
            end
            S_SAMPLE: begin
                if (!en) begin
                    state_d = S_IDLE;
                    hold_d  = 1'b0;
                    busy_d  = 1'b0;
                    arst_d  = 1'b1;
                end else if (cnt_q == 8'd0) begin
                    state_d          = S_CONV;
                    hold_d           = 1'b1;
                    data_d           = '0;
                    data_d[RES-1]    = 1'b1;
                    bit_d            = MSB_IDX;
                    cyc_d            = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_CONV: begin
                if (!en) begin
                    state_d = S_IDLE;
                    hold_d  = 1'b0;
                    busy_d  = 1'b0;
                    arst_d  = 1'b1;
                end else if (cyc_q != CYC_LAST) begin
                    cyc_d = cyc_q + CW'(1);
                end else begin
                    cyc_d         = '0;
                    data_d[bit_q] = cmp;
                    if (bit_q != '0) begin
                        data_d[bit_q - BW'(1)] = 1'b1;
                        bit_d                  = bit_q - BW'(1);
                    end else begin
                        // Bit 0 decided: publish, then either rescan the next channel or go idle.
                        res_d  = data_d;
                        ch_d   = b_q;
                        eoc_d  = 1'b1;
                        hold_d = 1'b0;
                        if (scan_go) begin
                            state_d = S_SAMPLE;
                            b_d     = b_q + 3'd1;
                            cnt_d   = n_q - 8'd1;
                            data_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            arst_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                arst_d  = 1'b1;
                hold_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= 8'd1;
            cnt_q   <= '0;
            bit_q   <= '0;
            cyc_q   <= '0;
            hold_q  <= 1'b0;
            arst_q  <= 1'b1;
            busy_q  <= 1'b0;
            eoc_q   <= 1'b0;
            b_q     <= '0;
            ch_q    <= '0;
            data_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
            hold_q  <= hold_d;
            arst_q  <= arst_d;
            busy_q  <= busy_d;
            eoc_q   <= eoc_d;
            b_q     <= b_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            res_q   <= res_d;
        end
    end

    assign adc_en    = en;
    assign adc_rst   = arst_q;
    assign adc_hold  = hold_q;
    assign adc_b     = b_q;
    assign adc_data  = data_q;
    assign result    = res_q;
    assign result_ch = ch_q;
    assign eoc       = eoc_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_ef_adc_sar_ctrl.sv
// Bench for ef_adc_sar_ctrl: transaction-level model (age counter + ideal quantiser) compared every cycle.
`timescale 1ns/1ps
module tb_ef_adc_sar_ctrl;
    localparam int RES = 10;
    localparam int BC  = 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           soc = 1'b0;
    logic [2:0]     chan = '0;
    logic [7:0]     sample_cycles = '0;
    logic           cmp;
`ifdef SAR_CTRL_SCAN_EN
    logic           scan = 1'b0;
`endif
    logic           adc_en, adc_rst, adc_hold, eoc, busy;
    logic [2:0]     adc_b, result_ch;
    logic [RES-1:0] adc_data, result;

    int  errors = 0;
    int  checks = 0;
    real vin = 0.0;
    real held_vin = 0.0;

    ef_adc_sar_ctrl #(.RES(RES), .BIT_CYC(BC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .soc(soc), .chan(chan),
        .sample_cycles(sample_cycles), .cmp(cmp),
`ifdef SAR_CTRL_SCAN_EN
        .scan(scan),
`endif
        .adc_en(adc_en), .adc_rst(adc_rst), .adc_hold(adc_hold), .adc_b(adc_b),
        .adc_data(adc_data), .result(result), .result_ch(result_ch),
        .eoc(eoc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Analog macro stand-in: track-and-hold plus ideal comparator.
    always @(posedge adc_hold) held_vin = vin;
    always_comb cmp = (held_vin > real'(adc_data));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Ideal SAR outcome: largest code strictly below the held input.
    function automatic int code_of(input real v);
        int c = 0;
        for (int k = 0; k < (1 << RES); k++)
            if (real'(k) < v) c = k;
        return c;
    endfunction

    // Reference model: one conversion is just an age counter from the soc edge.
    bit       m_busy = 0, m_hold = 0, m_eoc = 0, m_hold_rise = 0;
    int       m_age = 0, m_N = 1, m_res = 0;
    logic [2:0] m_ch = '0, m_resch = '0;
    real      m_vin = 0.0;
    logic     scan_lvl;
`ifdef SAR_CTRL_SCAN_EN
    assign scan_lvl = scan;
`else
    assign scan_lvl = 1'b0;
`endif

    task automatic model_step();
        if (!rst_n) begin
            m_busy = 0; m_hold = 0; m_eoc = 0; m_hold_rise = 0;
            m_age = 0; m_N = 1; m_res = 0; m_ch = '0; m_resch = '0;
        end else begin
            m_eoc = 0;
            m_hold_rise = 0;
            if (m_busy) begin
                if (!en) begin
                    m_busy = 0;
                    m_hold = 0;
                end else begin
                    m_age++;
                    if (m_age == m_N) begin
                        m_hold = 1; m_hold_rise = 1; m_vin = vin;
                    end
                    if (m_age == m_N + RES * BC) begin
                        m_eoc = 1; m_hold = 0;
                        m_res = code_of(m_vin); m_resch = m_ch;
                        if (scan_lvl) begin
                            m_age = 0; m_ch = m_ch + 3'd1;
                        end else begin
                            m_busy = 0;
                        end
                    end
                end
            end else if (en && soc) begin
                m_busy = 1; m_age = 0; m_ch = chan;
                m_N = (sample_cycles == 8'd0) ? 1 : int'(sample_cycles);
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("busy", busy, m_busy);
        chk("adc_rst", adc_rst, !m_busy);
        chk("adc_hold", adc_hold, m_hold);
        chk("adc_b", adc_b, m_ch);
        chk("eoc", eoc, m_eoc);
        chk("result", result, m_res);
        chk("result_ch", result_ch, m_resch);
        chk("adc_en", adc_en, en);
        if (m_hold_rise) chk("adc_data_msb", adc_data, 32'd1 << (RES - 1));
        if (m_eoc) chk("adc_data_final", adc_data, m_res);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input real v, input logic [2:0] ch, input logic [7:0] sc);
        vin = v; chan = ch; sample_cycles = sc; soc = 1'b1;
        tick();
        soc = 1'b0;
    endtask

    task automatic wait_eoc(output int edges);
        edges = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (eoc) begin
                edges = k;
                break;
            end
        end
        chk("eoc_seen", eoc, 1'b1);
        #1;
    endtask

    int e, extra, rv, sc_eff, k;
    logic [2:0] rc;
    logic [7:0] rsc;
    real rvin;

    initial begin
        en = 1'b1;
        #12 rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a conversion.
        start(500.5, 3'd3, 8'd2);
        repeat (5) tick();
        @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_adc_rst", adc_rst, 1'b1);
        chk("rst_hold", adc_hold, 1'b0);
        chk("rst_data", adc_data, 0);
        chk("rst_b", adc_b, 0);
        chk("rst_result", result, 0);
        chk("rst_result_ch", result_ch, 0);
        chk("rst_eoc", eoc, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_adc_rst", adc_rst, 1'b1);

        // Endpoints and sample_cycles=0.
        start(0.0, 3'd1, 8'd0);
        wait_eoc(e);
        chk("lat_sc0", e, 11);
        chk("res_zero", result, 10'h000);
        start(1023.7, 3'd2, 8'd1);
        wait_eoc(e);
        chk("res_full", result, 10'h3FF);

        // Nominal conversion.
        start(677.5, 3'd5, 8'd4);
        repeat (3) tick();
        chk("hold_pre", adc_hold, 1'b0);
        tick();
        chk("hold_rise", adc_hold, 1'b1);
        wait_eoc(e);
        chk("lat_n4", e + 4, 14);
        chk("res_677", result, 10'h2A5);
        chk("res_ch5", result_ch, 3'd5);

        // soc and chan changes while busy are ignored.
        start(677.5, 3'd5, 8'd4);
        repeat (7) tick();
        soc = 1'b1; chan = 3'd2;
        tick(); tick();
        soc = 1'b0;
        chk("busy_b_kept", adc_b, 3'd5);
        wait_eoc(e);
        chk("lat_ignored_soc", e + 9, 14);
        chk("ign_result_ch", result_ch, 3'd5);
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (eoc) extra++;
            #1;
        end
        chk("single_eoc", extra, 0);

        // Abort during the third bit trial.
        start(300.5, 3'd4, 8'd2);
        repeat (4) tick();
        en = 1'b0;
        tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_eoc", eoc, 1'b0);
        chk("abort_result", result, 10'h2A5);
        chk("abort_result_ch", result_ch, 3'd5);
        en = 1'b1;
        repeat (3) tick();

        // Back-to-back with soc held high.
        vin = 200.5; chan = 3'd1; sample_cycles = 8'd2; soc = 1'b1;
        tick();
        wait_eoc(e);
        chk("b2b_first", e, 12);
        wait_eoc(e);
        chk("b2b_second", e, 13);
        soc = 1'b0;
        chk("b2b_result", result, 10'd200);
        repeat (2) tick();

        // Randomised conversions with occasional aborts.
        for (int it = 0; it < 30; it++) begin
            rv   = $urandom_range(0, 2047);
            rvin = real'(rv) / 2.0;
            rc   = 3'($urandom_range(0, 7));
            rsc  = 8'($urandom_range(0, 6));
            sc_eff = (rsc == 8'd0) ? 1 : int'(rsc);
            start(rvin, rc, rsc);
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, sc_eff + RES);
                repeat (k - 1) tick();
                en = 1'b0;
                tick();
                en = 1'b1;
                chk("rand_abort_busy", busy, 1'b0);
            end else begin
                wait_eoc(e);
                chk("rand_lat", e, sc_eff + RES);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

`ifdef SAR_CTRL_SCAN_EN
        // Auto-scan over four channels, stopped before the fourth eoc.
        scan = 1'b1;
        start(100.5, 3'd6, 8'd3);
        for (int i = 0; i < 4; i++) begin
            wait_eoc(e);
            chk("scan_lat", e, 13);
            chk("scan_result", result, 10'h064);
            chk("scan_ch", result_ch, 3'(6 + i));
            if (i == 2) scan = 1'b0;
        end
        chk("scan_stop_busy", busy, 1'b0);
        repeat (3) tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end
endmodule
